// File: rtl/ebuf_pkg.sv
// Shared helpers for the ebuf_fifo elastic buffer: width functions and transfer encoding.
// The optional flush port is enabled by defining EBUF_FLUSH_EN.
package ebuf_pkg;

    // Pointer width; a single-entry buffer still gets a 1-bit pointer.
    function automatic int unsigned ebuf_clog2(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned ebuf_ptr_w(input int unsigned depth);
        return ebuf_clog2(depth);
    endfunction

    function automatic int unsigned ebuf_lvl_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Bit order matches {push, pop}.
    typedef enum logic [1:0] {
        XferNone = 2'b00,
        XferPop  = 2'b01,
        XferPush = 2'b10,
        XferBoth = 2'b11
    } xfer_e;

endpackage

// File: rtl/ebuf_ptr.sv
// Circular pointer register for ebuf_fifo: wraps DEPTH-1 -> 0 by explicit compare.
// clr has priority over inc.
module ebuf_ptr
    import ebuf_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = ebuf_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ebuf_fifo.sv
// Valid/ready elastic buffer with DEPTH-entry circular storage; handshakes decode only from
// the registered level. Define EBUF_FLUSH_EN to add the synchronous flush input.
module ebuf_fifo
    import ebuf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       upstream_vld,
    output logic                       upstream_rdy,
    input  logic [DATA_WIDTH-1:0]      upstream_data,
    output logic                       downstream_vld,
    input  logic                       downstream_rdy,
    output logic [DATA_WIDTH-1:0]      downstream_data,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef EBUF_FLUSH_EN
    ,
    input  logic                       flush
`endif
);

    localparam int unsigned PTR_W = ebuf_ptr_w(DEPTH);
    localparam int unsigned LVL_W = ebuf_lvl_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_d;
    logic                  push;
    logic                  pop;
    logic                  clr;
    xfer_e                 xfer;

    assign upstream_rdy   = (level_q != LVL_W'(DEPTH));
    assign downstream_vld = (level_q != '0);

    assign push = upstream_vld & upstream_rdy;
    assign pop  = downstream_vld & downstream_rdy;
    assign xfer = xfer_e'({push, pop});

`ifdef EBUF_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    ebuf_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .clr   (clr),
        .ptr   (wr_ptr)
    );

    ebuf_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .clr   (clr),
        .ptr   (rd_ptr)
    );

    // A push in a flush cycle is discarded, so the write is suppressed too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !clr) begin
            mem_q[wr_ptr] <= upstream_data;
        end
    end

    always_comb begin
        level_d = level_q;
        if (clr) begin
            level_d = '0;
        end else begin
            unique case (xfer)
                XferPush: level_d = level_q + LVL_W'(1);
                XferPop:  level_d = level_q - LVL_W'(1);
                default:  level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign downstream_data = mem_q[rd_ptr];
    assign level           = level_q;

endmodule

// File: tb/tb_ebuf_fifo.sv
// Randomised bench for ebuf_fifo at DEPTH 4, 3 and 1 against a shift-array reference model.
// Flush directed and random traffic is exercised when EBUF_FLUSH_EN is defined.
module tb_ebuf_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int dep [3] = '{4, 3, 1};

    logic       uvld [3];
    logic       urdy [3];
    logic       dvld [3];
    logic       drdy [3];
    logic       fl   [3];
    logic [7:0] udat [3];
    logic [7:0] ddat [3];
    logic [2:0] lvl4;
    logic [1:0] lvl3;
    logic [0:0] lvl1;
    int         lvl  [3];

    always_comb begin
        lvl[0] = int'(lvl4);
        lvl[1] = int'(lvl3);
        lvl[2] = int'(lvl1);
    end

    ebuf_fifo #(.DATA_WIDTH(8), .DEPTH(4)) u_d4 (
        .clk             (clk),
        .rst_n           (rst_n),
        .upstream_vld    (uvld[0]),
        .upstream_rdy    (urdy[0]),
        .upstream_data   (udat[0]),
        .downstream_vld  (dvld[0]),
        .downstream_rdy  (drdy[0]),
        .downstream_data (ddat[0]),
        .level           (lvl4)
`ifdef EBUF_FLUSH_EN
        ,
        .flush           (fl[0])
`endif
    );

    ebuf_fifo #(.DATA_WIDTH(8), .DEPTH(3)) u_d3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .upstream_vld    (uvld[1]),
        .upstream_rdy    (urdy[1]),
        .upstream_data   (udat[1]),
        .downstream_vld  (dvld[1]),
        .downstream_rdy  (drdy[1]),
        .downstream_data (ddat[1]),
        .level           (lvl3)
`ifdef EBUF_FLUSH_EN
        ,
        .flush           (fl[1])
`endif
    );

    ebuf_fifo #(.DATA_WIDTH(8), .DEPTH(1)) u_d1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .upstream_vld    (uvld[2]),
        .upstream_rdy    (urdy[2]),
        .upstream_data   (udat[2]),
        .downstream_vld  (dvld[2]),
        .downstream_rdy  (drdy[2]),
        .downstream_data (ddat[2]),
        .level           (lvl1)
`ifdef EBUF_FLUSH_EN
        ,
        .flush           (fl[2])
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", name, idx, act, exp,
                     $time);
        end
    endtask

    // Reference model: ordered contents held as a shift array, head at index 0.
    logic [7:0] mdat [3][8];
    int         mcnt [3] = '{0, 0, 0};

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    mcnt[i] = 0;
                end else begin
                    bit pu;
                    bit po;
                    pu = uvld[i] && (mcnt[i] != dep[i]);
                    po = (mcnt[i] != 0) && drdy[i];
                    if (po) begin
                        for (int k = 0; k < 7; k++) mdat[i][k] = mdat[i][k+1];
                        mcnt[i]--;
                    end
                    if (pu) begin
                        mdat[i][mcnt[i]] = udat[i];
                        mcnt[i]++;
                    end
                    if (fl[i]) mcnt[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check("upstream_rdy", i, int'(urdy[i]), int'(mcnt[i] != dep[i]));
            check("downstream_vld", i, int'(dvld[i]), int'(mcnt[i] != 0));
            check("level", i, lvl[i], mcnt[i]);
            if (mcnt[i] != 0) begin
                check("downstream_data", i, int'(ddat[i]), int'(mdat[i][0]));
            end else if (!rst_n) begin
                check("reset_data", i, int'(ddat[i]), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run0();
        drdy[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            uvld[0] = 1'b1;
            udat[0] = 8'(8'h11 * (k + 1));
            step();
        end
        udat[0] = 8'h55;
        @(negedge clk);
        check("full_level", 0, lvl[0], 4);
        check("full_rdy", 0, int'(urdy[0]), 0);
        step();
        uvld[0] = 1'b0;
        drdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_data", 0, int'(ddat[0]), (k + 1) * 'h11);
            step();
        end
        @(negedge clk);
        check("drain_empty_vld", 0, int'(dvld[0]), 0);
        step();

        uvld[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            udat[0] = 8'(8'h20 + k);
            step();
            @(negedge clk);
            check("stream_level", 0, lvl[0], 1);
            check("stream_data", 0, int'(ddat[0]), 'h20 + k);
        end
        uvld[0] = 1'b0;
        step();

`ifdef EBUF_FLUSH_EN
        drdy[0] = 1'b0;
        uvld[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            udat[0] = 8'(8'hA1 + k);
            step();
        end
        @(negedge clk);
        check("pre_flush_level", 0, lvl[0], 3);
        fl[0]   = 1'b1;
        udat[0] = 8'h99;
        step();
        fl[0]   = 1'b0;
        uvld[0] = 1'b0;
        @(negedge clk);
        check("flush_level", 0, lvl[0], 0);
        check("flush_vld", 0, int'(dvld[0]), 0);
        uvld[0] = 1'b1;
        udat[0] = 8'h5A;
        step();
        uvld[0] = 1'b0;
        drdy[0] = 1'b1;
        @(negedge clk);
        check("post_flush_head", 0, int'(ddat[0]), 'h5A);
        step();
`endif

        for (int c = 0; c < 300; c++) begin
            uvld[0] = 1'($urandom_range(0, 1));
            drdy[0] = 1'($urandom_range(0, 1));
            udat[0] = 8'($urandom);
`ifdef EBUF_FLUSH_EN
            fl[0] = ($urandom_range(0, 31) == 0);
`endif
            step();
        end
        uvld[0] = 1'b0;
        fl[0]   = 1'b0;
        drdy[0] = 1'b1;
    endtask

    task automatic run1();
        int accepted = 0;
        int cycles = 0;
        while (accepted < 200 && cycles < 4000) begin
            uvld[1] = ($urandom_range(0, 9) < 6);
            drdy[1] = 1'($urandom_range(0, 1));
            udat[1] = 8'($urandom);
            @(negedge clk);
            if (uvld[1] && urdy[1]) accepted++;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("d3_beats_in_budget", 1, int'(accepted >= 200), 1);
        uvld[1] = 1'b0;
        drdy[1] = 1'b1;
    endtask

    task automatic run2();
        int pops = 0;
        uvld[2] = 1'b1;
        drdy[2] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dvld[2] && drdy[2]) pops++;
            @(posedge clk);
            #1;
            udat[2] = 8'($urandom);
        end
        check("d1_half_rate", 2, pops, 20);
        for (int c = 0; c < 200; c++) begin
            uvld[2] = 1'($urandom_range(0, 1));
            drdy[2] = 1'($urandom_range(0, 1));
            udat[2] = 8'($urandom);
            step();
        end
        uvld[2] = 1'b0;
        drdy[2] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            uvld[i] = 1'b0;
            drdy[i] = 1'b0;
            fl[i]   = 1'b0;
            udat[i] = 8'h00;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rdy", 0, int'(urdy[0]), 1);
        check("reset_vld", 0, int'(dvld[0]), 0);
        check("reset_data_lit", 0, int'(ddat[0]), 0);
        check("reset_level", 0, lvl[0], 0);
        step();
        rst_n = 1'b1;

        fork
            run0();
            run1();
            run2();
        join

        // Reset in the middle of a cycle must empty the buffer immediately.
        drdy[0] = 1'b0;
        uvld[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            udat[0] = 8'(8'hC0 + k);
            step();
        end
        uvld[0] = 1'b0;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_level", 0, lvl[0], 0);
        check("midrst_vld", 0, int'(dvld[0]), 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
